rom_rr_arbiter: RTL and testbench



---
 rtl/rom_rr_arbiter_pkg.sv | 15 +
 rtl/rom_rr_arbiter_rr_pick.sv | 36 +++
 rtl/rom_rr_arbiter.sv | 115 +++++++++++
 tb/tb_rom_rr_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_rr_arbiter_pkg.sv
// rtl/rom_rr_arbiter_pkg.sv - shared constants for the ROM round-robin arbiter
//
// Purpose : FSM state encoding and default widths shared by the arbiter files.
// Contents: ST_IDLE / ST_WAIT / ST_RESP state codes (2'd3 is unused and is
//           decoded as idle), DEF_ADDR_W / DEF_DATA_W default widths.
package rom_rr_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int DEF_ADDR_W = 2;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/rom_rr_arbiter_rr_pick.sv
// rtl/rom_rr_arbiter_rr_pick.sv - combinational round-robin winner search
//
// Purpose : pick the first set request bit searching upward from
//           last_grant+1 (mod NUM_REQ), wrapping around.
// Ports   : req        in  NUM_REQ  request vector
//           last_grant in  ID_W     index granted most recently
//           winner     out ID_W     selected index (0 when nothing requests)
//           any_valid  out 1        at least one request bit is set
module rom_rr_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    winner,
    output logic               any_valid
);

    int idx;

    // Walk from the farthest candidate to the nearest one so the nearest
    // requesting index after last_grant is the assignment that sticks.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (req[idx[ID_W-1:0]]) begin
                winner    = idx[ID_W-1:0];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rom_rr_arbiter.sv
// rtl/rom_rr_arbiter.sv - round-robin sharing of one registered-read ROM port
//
// Purpose : arbitrate NUM_REQ valid/ready requesters onto a single ROM port
//           whose data returns one clock after the address, and return the
//           data with the requester id on one backpressured response channel.
// Ports   : clk, reset           clock, synchronous active-high reset
//           req_valid/req_ready  per-requester request handshake
//           req_addr             requester i at [i*ADDR_W +: ADDR_W]
//           rsp_valid/rsp_ready  response handshake
//           rsp_data, rsp_id     returned data and owning requester index
//           rom_addr, rom_rdata  external ROM address and registered data
module rom_rr_arbiter
    import rom_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_rdata
);

    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

    logic [ID_W-1:0]   winner;
    logic              any_valid;
    logic              is_wait, is_resp, is_idle;
    logic              can_accept, accept;
    logic [ADDR_W-1:0] win_addr;

    rom_rr_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .winner     (winner),
        .any_valid  (any_valid)
    );

    always_comb begin
        is_wait = (state_q == ST_WAIT);
        is_resp = (state_q == ST_RESP);
        // The unused code 2'd3 falls through to idle.
        is_idle = !is_wait && !is_resp;

        // Gating with reset keeps the handshake outputs quiet while reset is
        // held, so no accept can race the reset edge.
        can_accept = !reset && (is_idle || (is_resp && rsp_ready));
        accept     = can_accept && any_valid;

        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end

        win_addr = req_addr[winner*ADDR_W +: ADDR_W];

        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        rom_addr_d   = rom_addr_q;

        if (accept) begin
            last_grant_d = winner;
            rsp_id_d     = winner;
            rom_addr_d   = win_addr;
        end

        if (is_wait) begin
            state_d = ST_RESP;
        end else if (is_resp) begin
            if (rsp_ready) begin
                state_d = accept ? ST_WAIT : ST_IDLE;
            end
        end else begin
            state_d = accept ? ST_WAIT : ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            rsp_id_q     <= '0;
            rom_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            rom_addr_q   <= rom_addr_d;
        end
    end

    // The ROM output is static for a held rom_addr, so passing it straight
    // through keeps rsp_data stable during backpressure.
    assign rsp_valid = is_resp && !reset;
    assign rsp_data  = rom_rdata;
    assign rsp_id    = rsp_id_q;
    assign rom_addr  = rom_addr_q;

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// tb/tb_rom_rr_arbiter.sv - self-checking bench for rom_rr_arbiter
module tb_rom_rr_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_valid;
    logic [7:0] req_addr;
    logic [3:0] req_ready;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [1:0] rsp_id;
    logic [1:0] rom_addr;
    logic [7:0] rom_rdata;

    logic [7:0] rom_mem [4];

    always #5 clk = ~clk;

    always @(posedge clk) rom_rdata <= rom_mem[rom_addr];

    rom_rr_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stimulus state: requester i keeps its request up while pend[i] is set.
    bit       pend   [N];
    bit [1:0] paddr  [N];
    bit       refill [N];
    bit       rst;
    bit       rr;

    // Transaction-level reference: who is owed a response and since when.
    int  cyc;
    int  m_last;
    bit  m_inflight;
    int  m_acc_cyc;
    int  m_id;
    int  m_addr;

    // Observations from the most recent step (DUT values).
    logic [3:0] o_ready;
    logic       o_rv;
    logic [7:0] o_data;
    logic [1:0] o_id;
    logic [1:0] o_addr;

    int grants [$];
    int rsp_log [$];

    task automatic model_reset();
        m_inflight = 1'b0;
        m_last     = N - 1;
        m_id       = 0;
        m_addr     = 0;
    endtask

    task automatic step();
        bit   exp_rv, can, found;
        int   w;
        logic [3:0] exp_rdy;
        @(negedge clk);
        reset     = rst;
        rsp_ready = rr;
        for (int i = 0; i < N; i++) begin
            req_valid[i]          = pend[i];
            req_addr[i*2 +: 2]    = paddr[i];
        end
        #1;
        exp_rv = !rst && m_inflight && (cyc >= m_acc_cyc + 2);
        can    = !rst && (!m_inflight || (exp_rv && rr));
        found  = 1'b0;
        w      = 0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (!found && pend[idx]) begin
                found = 1'b1;
                w     = idx;
            end
        end
        exp_rdy = (can && found) ? 4'(1 << w) : 4'd0;

        o_ready = req_ready;
        o_rv    = rsp_valid;
        o_data  = rsp_data;
        o_id    = rsp_id;
        o_addr  = rom_addr;

        check("req_ready", int'(req_ready), int'(exp_rdy));
        check("rsp_valid", int'(rsp_valid), int'(exp_rv));
        if (exp_rv) check("rsp_data", int'(rsp_data), int'(rom_mem[m_addr]));
        check("rsp_id", int'(rsp_id), m_id);
        check("rom_addr", int'(rom_addr), m_addr);

        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && req_valid[i]) grants.push_back(i);
        end
        if (rsp_valid && rsp_ready) rsp_log.push_back(int'(rsp_data));

        if (rst) begin
            model_reset();
        end else if (can && found) begin
            m_last     = w;
            m_id       = w;
            m_addr     = paddr[w];
            m_acc_cyc  = cyc;
            m_inflight = 1'b1;
            if (!refill[w]) pend[w] = 1'b0;
        end else if (exp_rv && rr) begin
            m_inflight = 1'b0;
        end
        cyc++;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            pend[i]   = 1'b0;
            paddr[i]  = 2'd0;
            refill[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        clear_reqs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        grants.delete();
        rsp_log.delete();
    endtask

    initial begin
        int mark, pos;
        rom_mem[0] = 8'h11;
        rom_mem[1] = 8'h22;
        rom_mem[2] = 8'h33;
        rom_mem[3] = 8'h44;
        cyc = 0;
        rr  = 1'b1;
        model_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        rsp_ready = 1'b1;

        // Reset state.
        do_reset();
        step();
        check("reset_rv", int'(o_rv), 0);
        check("reset_rom_addr", int'(o_addr), 0);
        check("reset_id", int'(o_id), 0);

        // Single request from requester 2 at address 3.
        pend[2] = 1'b1; paddr[2] = 2'd3;
        step();
        check("single_ready", int'(o_ready), 4);
        step();
        check("single_wait_rv", int'(o_rv), 0);
        step();
        check("single_rv", int'(o_rv), 1);
        check("single_data", int'(o_data), 8'h44);
        check("single_id", int'(o_id), 2);

        // All four requesting continuously: strict rotation from 0.
        do_reset();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1; paddr[i] = 2'(i); refill[i] = 1'b1;
        end
        for (int c = 0; c < 12; c++) step();
        check("rot_count", (grants.size() >= 5) ? 1 : 0, 1);
        check("rsp_count", (rsp_log.size() >= 5) ? 1 : 0, 1);
        for (int g = 0; g < 5; g++) begin
            if (g < grants.size()) check("rot_grant", grants[g], g % N);
            if (g < rsp_log.size()) check("rot_data", rsp_log[g], int'(rom_mem[g % N]));
        end

        // Backpressure: response for requester 1 held for 5 cycles.
        do_reset();
        rr = 1'b0;
        pend[1] = 1'b1; paddr[1] = 2'd1;
        step(); step(); step();
        pend[0] = 1'b1; pend[2] = 1'b1; paddr[2] = 2'd2;
        mark = grants.size();
        for (int c = 0; c < 5; c++) begin
            step();
            check("bp_rv", int'(o_rv), 1);
            check("bp_data", int'(o_data), 8'h22);
            check("bp_id", int'(o_id), 1);
            check("bp_ready", int'(o_ready), 0);
        end
        check("bp_no_grant", grants.size(), mark);
        rr = 1'b1;
        step();
        check("bp_next_grant", int'(o_ready), 4);

        // Back-to-back: requester 1 accepted in the handshake cycle.
        do_reset();
        pend[0] = 1'b1; paddr[0] = 2'd2;
        step();
        pend[1] = 1'b1; paddr[1] = 2'd0;
        step();
        check("b2b_wait_ready", int'(o_ready), 0);
        step();
        check("b2b_rv", int'(o_rv), 1);
        check("b2b_ready", int'(o_ready), 2);
        step();
        step();
        check("b2b_rv2", int'(o_rv), 1);
        check("b2b_data2", int'(o_data), 8'h11);
        check("b2b_id2", int'(o_id), 1);

        // Fairness: requester 0 always asks, requester 3 joins later.
        do_reset();
        pend[0] = 1'b1; refill[0] = 1'b1;
        step(); step(); step();
        pend[3] = 1'b1; paddr[3] = 2'd3;
        mark = grants.size();
        for (int c = 0; c < 8; c++) step();
        pos = -1;
        for (int g = mark; g < grants.size(); g++) begin
            if (pos < 0 && grants[g] == 3) pos = g - mark;
        end
        check("fair", (pos >= 0 && pos <= 1) ? 1 : 0, 1);

        // Reset while in WAIT drops the transaction and restores priority.
        do_reset();
        pend[2] = 1'b1; paddr[2] = 2'd1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        pend[0] = 1'b1; pend[3] = 1'b1; paddr[3] = 2'd2;
        step();
        check("rstw_rv", int'(o_rv), 0);
        check("rstw_addr", int'(o_addr), 0);
        check("rstw_grant", int'(o_ready), 1);
        step();
        check("rstw_rv2", int'(o_rv), 0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    pend[i]  = 1'b1;
                    paddr[i] = 2'($urandom % 4);
                end else if (pend[i] && ($urandom % 16 == 0)) begin
                    pend[i] = 1'b0;
                end
            end
            rr  = ($urandom % 4) != 0;
            rst = ($urandom % 200) == 0;
            step();
        end
        rst = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
